spi_rx: RTL and testbench

SPI slave receiver: samples an external SPI master on SCLK/SS/MOSI, assembles 32-bit MSB-first words, and buffers them in a 4-entry RX FIFO readable over the AHB slave port. It is the receive-side counterpart of spi_tx and sits on the same AHB bus as a separate slave. Bus-facing registers provide enable, status, sticky error flags, and a pop-on-read data register.

---
 rtl/spi_rx_pkg.sv | 32 +++
 rtl/fifo_buffer.sv | 44 ++++
 rtl/spi_rx_control.sv | 99 +++++++++
 rtl/spi_rx.sv | 103 ++++++++++
 tb/tb_spi_rx.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_rx_pkg.sv
// Shared SPI/AHB defines (AHB_ADDR_WIDTH, DATA_WIDTH, register offsets, STATUS
// bit indices) plus the spi_rx package. Optional feature macro used by this
// block: SPI_RX_FRAME_CHECK_EN (enables FRAME_ERR detection and STATUS bit3).
`ifndef SPI_DEFINES_SV
`define SPI_DEFINES_SV
`define AHB_ADDR_WIDTH      32
`define DATA_WIDTH          32
`define SPI_RX_CTRL_ADDR    4'h0
`define SPI_RX_STATUS_ADDR  4'h4
`define SPI_RX_DATA_ADDR    4'h8
`define SPI_STATUS_EMPTY    0
`define SPI_STATUS_FULL     1
`define SPI_STATUS_OVERRUN  2
`define SPI_STATUS_FRAME    3
`endif

package spi_rx_pkg;
  localparam int WORD_W    = 32;
  localparam int BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PUSH  = 2'd2
  } rx_state_t;

  // AHB address-phase info carried into the data phase
  typedef struct packed {
    logic       write;
    logic [3:0] addr;
  } ahb_dp_t;
endpackage

// File: rtl/fifo_buffer.sv
// Synchronous FIFO, 2**pointer_width entries, head visible on rd_data.
// A write into a full FIFO is accepted only when a read happens the same cycle.
module fifo_buffer #(
  parameter int pointer_width = 2,
  parameter int data_width    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  empty,
  output logic                  full
);
  localparam int DEPTH = 1 << pointer_width;

  logic [data_width-1:0]  mem [DEPTH];
  logic [pointer_width:0] wr_ptr, rd_ptr;
  logic                   do_rd, do_wr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[pointer_width] != rd_ptr[pointer_width]) &&
                   (wr_ptr[pointer_width-1:0] == rd_ptr[pointer_width-1:0]);
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr[pointer_width-1:0]];

  // Pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage (no reset needed, guarded by pointers)
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[pointer_width-1:0]] <= wr_data;
  end
endmodule

// File: rtl/spi_rx_control.sv
// SPI mode-0 receive front end: input synchronizers, SCLK/SS edge detect,
// 32-bit MSB-first shift register, bit counter and receive FSM.
// FRAME_ERR source only exists when SPI_RX_FRAME_CHECK_EN is defined.
module spi_rx_control
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              push,
  output logic [WORD_W-1:0] word,
  output logic              frame_err
);
  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   rise, ss_fall, ss_rise, shift_en;
  logic [BIT_CNT_W-1:0]   cnt;
  logic [WORD_W-1:0]      sh;
  rx_state_t              state, state_n;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign ss_s    = ss_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign rise    = sclk_s & ~sclk_d;
  assign ss_fall = ss_d & ~ss_s;
  assign ss_rise = ~ss_d & ss_s;
  assign word    = sh;

  // Synchronizer chains and edge-detect history, reset to idle bus levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      ss_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next state, push strobe and frame-error pulse
  always_comb begin
    state_n   = state;
    push      = 1'b0;
    shift_en  = 1'b0;
    frame_err = 1'b0;
    case (state)
      ST_IDLE:  if (enable && ss_fall) state_n = ST_SHIFT;
      ST_SHIFT: begin
        if (!enable) begin
          state_n = ST_IDLE;
        end else if (ss_rise) begin
          state_n = ST_IDLE;
`ifdef SPI_RX_FRAME_CHECK_EN
          frame_err = (cnt != '0);
`endif
        end else if (rise) begin
          shift_en = 1'b1;
          if (cnt == BIT_CNT_W'(WORD_W - 1)) state_n = ST_PUSH;
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_n = (enable && !ss_s) ? ST_SHIFT : ST_IDLE;
      end
      default:  state_n = ST_IDLE;
    endcase
  end

  // Shift register and bit counter; counter wraps to 0 after bit 31
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sh  <= '0;
    end else if (state == ST_IDLE) begin
      cnt <= '0;
    end else if (shift_en) begin
      sh  <= {sh[WORD_W-2:0], mosi_s};
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/spi_rx.sv
// SPI slave receiver top: AHB decode, CTRL/STATUS/DATA registers, RX FIFO.
// Optional SPI_RX_FRAME_CHECK_EN adds the sticky FRAME_ERR flag (STATUS bit3).
module spi_rx
  import spi_rx_pkg::*;
#(
  parameter int FIFO_PTR_W  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       HSEL,
  input  logic                       HTRANS,
  input  logic [`AHB_ADDR_WIDTH-1:0] HADDR,
  input  logic                       HWRITE,
  input  logic                       HREADY,
  output logic                       HREADY_RESP,
  input  logic [`DATA_WIDTH-1:0]     HWDATA,
  output logic [`DATA_WIDTH-1:0]     HRDATA,
  input  logic                       SCLK,
  input  logic                       SS,
  input  logic                       MOSI
);
  ahb_dp_t           dp;
  logic              dp_valid, rd_hit, wr_hit, pop;
  logic              enable, overrun, frame_err, push, fe_set, empty, full;
  logic [WORD_W-1:0] word, head;
  logic              unused;

  assign HREADY_RESP = 1'b1;
  assign rd_hit      = dp_valid & ~dp.write;
  assign wr_hit      = dp_valid & dp.write;
  assign pop         = rd_hit & (dp.addr == `SPI_RX_DATA_ADDR) & ~empty;
  assign unused      = ^{HADDR[`AHB_ADDR_WIDTH-1:4], HWDATA, fe_set};

  spi_rx_control #(.SYNC_STAGES(SYNC_STAGES)) u_ctrl (
    .clk(CLK), .rst_n(RST_N), .enable(enable),
    .sclk(SCLK), .ss(SS), .mosi(MOSI),
    .push(push), .word(word), .frame_err(fe_set)
  );

  fifo_buffer #(.pointer_width(FIFO_PTR_W), .data_width(WORD_W)) u_fifo (
    .clk(CLK), .rst_n(RST_N),
    .wr_en(push), .wr_data(word), .rd_en(pop),
    .rd_data(head), .empty(empty), .full(full)
  );

  // Capture the AHB address phase for use in the following data phase
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dp_valid <= 1'b0;
      dp       <= '0;
    end else begin
      dp_valid <= HSEL & HTRANS & HREADY;
      dp       <= '{write: HWRITE, addr: HADDR[3:0]};
    end
  end

  // CTRL enable and sticky OVERRUN (new event wins over a same-cycle clear)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      enable  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (wr_hit && dp.addr == `SPI_RX_CTRL_ADDR) enable <= HWDATA[0];
      if (push && full && !pop)
        overrun <= 1'b1;
      else if (wr_hit && dp.addr == `SPI_RX_STATUS_ADDR && HWDATA[`SPI_STATUS_OVERRUN])
        overrun <= 1'b0;
    end
  end

`ifdef SPI_RX_FRAME_CHECK_EN
  // Sticky FRAME_ERR, write-1-to-clear
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      frame_err <= 1'b0;
    else if (fe_set)
      frame_err <= 1'b1;
    else if (wr_hit && dp.addr == `SPI_RX_STATUS_ADDR && HWDATA[`SPI_STATUS_FRAME])
      frame_err <= 1'b0;
  end
`else
  assign frame_err = 1'b0;
`endif

  // Read mux: zero outside a read data phase and for unmapped addresses
  always_comb begin
    HRDATA = '0;
    if (rd_hit) begin
      case (dp.addr)
        `SPI_RX_CTRL_ADDR:   HRDATA[0] = enable;
        `SPI_RX_STATUS_ADDR: begin
          HRDATA[`SPI_STATUS_EMPTY]   = empty;
          HRDATA[`SPI_STATUS_FULL]    = full;
          HRDATA[`SPI_STATUS_OVERRUN] = overrun;
          HRDATA[`SPI_STATUS_FRAME]   = frame_err;
        end
        `SPI_RX_DATA_ADDR:   HRDATA = empty ? '0 : head;
        default:             HRDATA = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: queue-based model of the FIFO and flags,
// directed scenarios pinned by literals, then a randomized traffic phase.
module tb_spi_rx;
  logic        CLK = 1'b0;
  logic        RST_N, HSEL, HTRANS, HWRITE, HREADY, HREADY_RESP;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic        SCLK, SS, MOSI;

  int checks = 0;
  int errors = 0;

  // Behavioural model: FIFO contents and flags
  logic [31:0] mq[$];
  bit          m_ovr, m_fe, m_en;
`ifdef SPI_RX_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  spi_rx dut (
    .CLK(CLK), .RST_N(RST_N), .HSEL(HSEL), .HTRANS(HTRANS), .HADDR(HADDR),
    .HWRITE(HWRITE), .HREADY(HREADY), .HREADY_RESP(HREADY_RESP),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .SCLK(SCLK), .SS(SS), .MOSI(MOSI)
  );

  always #5 CLK = ~CLK;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_status();
    return {28'd0, m_fe, m_ovr, mq.size() == 4, mq.size() == 0};
  endfunction

  // Expected read value; a DATA read pops the model
  function automatic logic [31:0] m_read(input logic [3:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      4'h0: v = {31'd0, m_en};
      4'h4: v = m_status();
      4'h8: if (mq.size() != 0) v = mq.pop_front();
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  task automatic m_push(input logic [31:0] w);
    if (mq.size() == 4) m_ovr = 1'b1;
    else                mq.push_back(w);
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge CLK);
    HSEL = 1; HTRANS = 1; HWRITE = 1; HADDR = {28'd0, a};
    @(negedge CLK);
    HSEL = 0; HTRANS = 0; HWRITE = 0; HWDATA = d;
    @(negedge CLK);
    if (a == 4'h0) m_en = d[0];
    if (a == 4'h4) begin
      if (d[2]) m_ovr = 1'b0;
      if (d[3] && FC) m_fe = 1'b0;
    end
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge CLK);
    HSEL = 1; HTRANS = 1; HWRITE = 0; HADDR = {28'd0, a};
    @(negedge CLK);
    d = HRDATA;
    chk("hready_resp", {31'd0, HREADY_RESP}, 32'd1);
    HSEL = 0; HTRANS = 0;
    @(negedge CLK);
  endtask

  // Read checked against the model only
  task automatic rd_chk(input logic [3:0] a, input string name);
    logic [31:0] e, v;
    e = m_read(a);
    ahb_read(a, v);
    chk(name, v, e);
  endtask

  // Read checked against the model, with the model pinned to a literal
  task automatic rd_lit(input logic [3:0] a, input string name, input logic [31:0] lit);
    logic [31:0] e, v;
    e = m_read(a);
    chk({name, "_model"}, e, lit);
    ahb_read(a, v);
    chk(name, v, e);
  endtask

  task automatic spi_bit(input logic b);
    MOSI = b;
    repeat ($urandom_range(3, 5)) @(negedge CLK);
    SCLK = 1;
    repeat ($urandom_range(3, 5)) @(negedge CLK);
    SCLK = 0;
  endtask

  task automatic spi_bits(input logic [31:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) spi_bit(w[31-i]);
  endtask

  task automatic ss_low();
    SS = 0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic ss_high();
    repeat (6) @(negedge CLK);
    SS = 1;
    repeat (6) @(negedge CLK);
  endtask

  task automatic send_word(input logic [31:0] w);
    ss_low();
    spi_bits(w, 0, 31);
    ss_high();
    if (m_en) m_push(w);
  endtask

  initial begin
    logic [31:0] w;
    RST_N = 0; HSEL = 0; HTRANS = 0; HWRITE = 0; HREADY = 1;
    HADDR = '0; HWDATA = '0; SCLK = 0; SS = 1; MOSI = 0;
    m_ovr = 0; m_fe = 0; m_en = 0;
    repeat (3) @(negedge CLK);
    chk("rst_hready", {31'd0, HREADY_RESP}, 32'd1);
    chk("rst_hrdata", HRDATA, 32'd0);
    RST_N = 1;
    @(negedge CLK);
    rd_lit(4'h0, "rst_ctrl", 32'd0);
    rd_lit(4'h4, "rst_status", 32'd1);

    // Single frame
    ahb_write(4'h0, 32'd1);
    rd_lit(4'h0, "ctrl_en", 32'd1);
    send_word(32'hA5A5_0F0F);
    rd_lit(4'h4, "t1_status", 32'd0);
    rd_lit(4'h8, "t1_data", 32'hA5A5_0F0F);
    rd_lit(4'h4, "t1_empty", 32'd1);

    // Overrun: five words into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_word(i);
    rd_lit(4'h4, "t2_full_ovr", 32'h6);
    for (int i = 1; i <= 4; i++) rd_lit(4'h8, "t2_data", i);
    rd_lit(4'h8, "t2_empty_read", 32'd0);
    rd_lit(4'h4, "t2_status", 32'h5);
    ahb_write(4'h4, 32'h4);
    rd_lit(4'h4, "t2_ovr_clr", 32'd1);
    rd_lit(4'hC, "unmapped", 32'd0);

    // Three words in one SS-low frame
    ss_low();
    spi_bits(32'h1111_1111, 0, 31); m_push(32'h1111_1111);
    spi_bits(32'h2222_2222, 0, 31); m_push(32'h2222_2222);
    spi_bits(32'h3333_3333, 0, 31); m_push(32'h3333_3333);
    ss_high();
    rd_lit(4'h8, "t3_w0", 32'h1111_1111);
    rd_lit(4'h8, "t3_w1", 32'h2222_2222);
    rd_lit(4'h8, "t3_w2", 32'h3333_3333);
    rd_lit(4'h4, "t3_status", 32'd1);

    // Short frame (17 bits) then a full word
    ss_low();
    spi_bits(32'h5A5A_5A5A, 0, 16);
    ss_high();
    m_fe = FC;
    send_word(32'hDEAD_BEEF);
    rd_lit(4'h4, "t4_status", FC ? 32'h8 : 32'h0);
    rd_lit(4'h8, "t4_data", 32'hDEAD_BEEF);
    rd_lit(4'h4, "t4_after", FC ? 32'h9 : 32'h1);
    ahb_write(4'h4, 32'h8);
    rd_lit(4'h4, "t4_fe_clr", 32'd1);

    // Disable mid-frame, re-enable, then a fresh frame
    ss_low();
    spi_bits(32'hFFFF_FFFF, 0, 9);
    ahb_write(4'h0, 32'd0);
    ahb_write(4'h0, 32'd1);
    spi_bits(32'hFFFF_FFFF, 10, 31);
    ss_high();
    send_word(32'h0000_0001);
    rd_lit(4'h4, "t5_status", 32'd0);
    rd_lit(4'h8, "t5_data", 32'h0000_0001);
    rd_lit(4'h4, "t5_empty", 32'd1);

    // Reset mid-frame with data and OVERRUN pending
    for (int i = 0; i < 5; i++) send_word(32'h70 + i);
    ss_low();
    spi_bits(32'h1234_5678, 0, 9);
    RST_N = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1;
    mq.delete(); m_ovr = 0; m_fe = 0; m_en = 0;
    spi_bits(32'h1234_5678, 10, 31);
    ss_high();
    rd_lit(4'h0, "t6_ctrl", 32'd0);
    rd_lit(4'h4, "t6_status", 32'd1);
    rd_lit(4'h8, "t6_data", 32'd0);
    ahb_write(4'h0, 32'd1);
    send_word(32'hCAFE_F00D);
    rd_lit(4'h8, "t6_cafe", 32'hCAFE_F00D);
    rd_lit(4'h4, "t6_empty", 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          w = $urandom();
          send_word(w);
        end
        2: rd_chk(4'h8, "rnd_data");
        3: rd_chk(4'h4, "rnd_status");
        default: if (m_ovr) ahb_write(4'h4, 32'h4);
                 else       rd_chk(4'h0, "rnd_ctrl");
      endcase
    end
    for (int i = 0; i < 5; i++) rd_chk(4'h8, "drain_data");
    rd_chk(4'h4, "drain_status");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
